// File: rtl/rv_word_unpacker.sv
// rtl/rv_word_unpacker.sv - buffers 64-bit words in a small FIFO and serializes each into ELEM_W lanes
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   upstream word valid
//   in_ready   out  a word can be accepted (registered count only)
//   in_data    in   upstream word, WORD_W bits
//   out_valid  out  an element is available
//   out_ready  in   downstream accepts the element
//   out_data   out  current element, ELEM_W bits (zero when out_valid is low)
//   out_idx    out  lane index of the current element within its word
//   out_last   out  current element is the last lane of its word
//   count      out  words held, including the word being drained
//
// Build option: UNPACK_MSB_FIRST_EN selects most-significant-lane-first order.

module rv_word_unpacker #(
  parameter int WORD_W = 64,
  parameter int ELEM_W = 16,
  parameter int DEPTH  = 2,
  localparam int N     = WORD_W / ELEM_W,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic {
    ST_EMPTY,
    ST_DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic              elem_fire;
  logic [WORD_W-1:0] head;
  logic [ELEM_W-1:0] lanes [N];

  // Full is judged from the registered count alone, so a same-cycle pop never
  // opens the input and there is no combinational out_ready -> in_ready path.
  assign in_ready  = !reset && (count < FULL_CNT);
  assign push      = in_valid && in_ready;
  assign elem_fire = out_valid && out_ready;
  assign pop       = elem_fire && (out_idx == LAST_IDX);
  assign head      = mem[rd_ptr];
  assign out_last  = out_valid && (out_idx == LAST_IDX);

  // Lane slicing of the head word; order fixed at build time.
  for (genvar k = 0; k < N; k++) begin : g_lane
`ifdef UNPACK_MSB_FIRST_EN
    assign lanes[k] = head[WORD_W-1-k*ELEM_W -: ELEM_W];
`else
    assign lanes[k] = head[k*ELEM_W +: ELEM_W];
`endif
  end

  // Stale FIFO contents must never leak out, so the element bus is gated.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = lanes[out_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // EMPTY holds no words; DRAIN presents the head word lane by lane. The
  // state leaves DRAIN only when the last word's final lane goes out with no
  // replacement arriving on the same edge.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (pop && !push && (count == ONE_CNT)) begin
          state_nxt = ST_EMPTY;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Word storage carries no reset; a slot is only read after it is written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out_idx <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + ONE_CNT;
      end else if (pop && !push) begin
        count <= count - ONE_CNT;
      end
      if (elem_fire) begin
        out_idx <= pop ? '0 : out_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: doc/rv_word_unpacker.md
# rv_word_unpacker

Downstream consumer of the 64-bit ready/valid transfer stage: accepts 64-bit words through a valid/ready handshake, buffers them in a small FIFO, and serializes each word into fixed-width operand elements, one per cycle, for the systolic MAC array feeder. It absorbs bursts from the transfer stage while the array consumes elements at its own rate under independent backpressure.

## Interface

Parameters:
- `WORD_W`, 64: input word width.
- `ELEM_W`, 16: output element width; `WORD_W % ELEM_W == 0`. N = `WORD_W/ELEM_W` (4 by default).
- `DEPTH`, 2: FIFO depth in words; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word.
- `in_data`  in  WORD_W  upstream word.
- `out_valid`  out  1  element available.
- `out_ready`  in  1  downstream accepts element.
- `out_data`  out  ELEM_W  current element.
- `out_idx`  out  max(1,$clog2(N))  lane index of current element.
- `out_last`  out  1  current element is last lane of its word.
- `count`  out  $clog2(DEPTH+1)  words held (including the word being drained).

## Operation

- Push: `in_valid && in_ready` at a rising edge writes `in_data` at the write pointer; count +1.
- `in_ready = !reset && (count < DEPTH)`. Depends only on registered count; no combinational path from `out_ready`. When full, no push, even if a pop occurs the same cycle.
- FSM: EMPTY (count==0) / DRAIN (count>0). EMPTY→DRAIN on push; DRAIN→EMPTY on final-lane pop with no simultaneous push and count==1.
- `out_valid = (count != 0)`. `out_data` = lane `out_idx` of head word; lane k = `head[k*ELEM_W +: ELEM_W]` (LSB-first default).
- Element handshake `out_valid && out_ready`: if `out_idx == N-1` pop the head word (read pointer +1, count −1) and reset `out_idx` to 0; otherwise `out_idx` +1.
- `out_last = out_valid && (out_idx == N-1)`.
- Simultaneous push and word pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- `in_data` is ignored when not accepted.

## Timing

- Reset (async assert): count, pointers, `out_idx` = 0; `out_valid` = 0, `out_last` = 0, `out_data` = 0, `in_ready` = 0 while reset is high and 1 in the first cycle after deassertion. FIFO contents are not reset but are never visible.
- Reset mid-word: all buffered words and the partial word are discarded; no further elements are emitted.
- Latency: word accepted at edge k gives `out_valid` = 1 with lane 0 visible in the cycle after edge k.
- Throughput: one element per cycle with `out_ready` held high. One word per N cycles; input never stalls in steady state for DEPTH ≥ 2.
- While `out_valid && !out_ready`: `out_data`, `out_idx`, `out_last` are held stable.
- `out_data` = 0 whenever `out_valid` = 0.

## Configuration

- `UNPACK_MSB_FIRST_EN`: when defined, lane k = `head[WORD_W-1-k*ELEM_W -: ELEM_W]` (most significant element first). `out_idx` and `out_last` semantics are unchanged.
- Undefined: LSB-first order as above.

## Test plan

- Single word `64'hDEADBEEFCAFEBABE`, `out_ready` = 1 → `out_data` = BABE, CAFE, BEEF, DEAD on 4 consecutive cycles; `out_idx` = 0..3; `out_last` only on DEAD; `count` returns to 0 and `out_valid` drops.
- `out_ready` = 0, offer 3 words back-to-back → first 2 accepted, `count` = 2, `in_ready` = 0, 3rd held; raise `out_ready` → 8 elements in order, 3rd word accepted the cycle after `count` falls to 1.
- Backpressure mid-word: drop `out_ready` at `out_idx` = 2 for 3 cycles → `out_data` = BEEF and `out_idx` = 2 held stable; resume at DEAD.
- Push coinciding with last-lane pop at count = 1 → count stays 1; next word's lane 0 appears the following cycle with no bubble.
- Assert `reset` at `out_idx` = 1 with 2 words buffered → immediately `out_valid` = 0, `count` = 0, `out_data` = 0; after release a new word streams from lane 0.
- Build with `UNPACK_MSB_FIRST_EN` → word `64'hDEADBEEFCAFEBABE` yields DEAD, BEEF, CAFE, BABE; `out_last` on BABE.
